// File: rtl/inst_decode_pipe_if.sv
// Shared RV32I decode types plus the fetch-side/execute-side handshake bundle of inst_decode_pipe.
package inst_decode_pipe_pkg;

  typedef enum logic [6:0] {
    OPC_LOAD     = 7'h03,
    OPC_MISC_MEM = 7'h0F,
    OPC_OP_IMM   = 7'h13,
    OPC_AUIPC    = 7'h17,
    OPC_STORE    = 7'h23,
    OPC_OP       = 7'h33,
    OPC_LUI      = 7'h37,
    OPC_BRANCH   = 7'h63,
    OPC_JALR     = 7'h67,
    OPC_JAL      = 7'h6F,
    OPC_SYSTEM   = 7'h73
  } tOpcodeEnum;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [31:0] curPc;
    logic [4:0]  rs1Addr;
    logic [4:0]  rs2Addr;
    logic [4:0]  rdAddr;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } tDecodedInst;

endpackage

interface inst_decode_pipe_if;
  import inst_decode_pipe_pkg::*;

  logic        iValid;
  logic        oReady;
  logic [31:0] iInst;
  logic [31:0] iCurPc;
  logic        iFlush;
  logic        oValid;
  logic        iReady;
  tDecodedInst oDecoded;
  logic        oIllegal;

  modport slave (
    input  iValid, iInst, iCurPc, iFlush, iReady,
    output oReady, oValid, oDecoded, oIllegal
  );

  modport master (
    output iValid, iInst, iCurPc, iFlush, iReady,
    input  oReady, oValid, oDecoded, oIllegal
  );

endinterface

// File: rtl/inst_decode_pipe.sv
// RV32I decoder: cStages register stages (= no-stall latency), valid/ready with a combinational ready chain, flush.
// Illegal-instruction flag only when INST_DECODE_ILLEGAL_CHK_EN is defined; otherwise oIllegal is tied 0.
module inst_decode_pipe
  import inst_decode_pipe_pkg::*;
#(
  parameter int          cStages  = 2,
  parameter logic [31:0] cResetPc = 32'h0
) (
  input logic               iClk,
  input logic               iRst,
  inst_decode_pipe_if.slave io
);

  localparam int cLast = cStages - 1;

  logic [cStages-1:0] v_q, v_d, stage_en;
  logic               accept, src_vld;
  logic [31:0]        src_inst, src_pc;
  tDecodedInst        dec_q, dec_d, idle_dec;

  function automatic tDecodedInst decode(input logic [31:0] inst, input logic [31:0] pc);
    tDecodedInst d;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    imm_i = {{20{inst[31]}}, inst[31:20]};
    imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    imm_u = {inst[31:12], 12'b0};
    imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    d        = '0;
    d.opcode = inst[6:0];
    d.curPc  = pc;
    case (inst[6:0])
      OPC_OP: begin
        d.rs1Addr = inst[19:15];
        d.rs2Addr = inst[24:20];
        d.rdAddr  = inst[11:7];
        d.funct3  = inst[14:12];
        d.funct7  = inst[31:25];
      end
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
        d.rs1Addr = inst[19:15];
        d.rdAddr  = inst[11:7];
        d.funct3  = inst[14:12];
        d.imm     = imm_i;
      end
      OPC_STORE: begin
        d.rs1Addr = inst[19:15];
        d.rs2Addr = inst[24:20];
        d.funct3  = inst[14:12];
        d.imm     = imm_s;
      end
      OPC_BRANCH: begin
        d.rs1Addr = inst[19:15];
        d.rs2Addr = inst[24:20];
        d.funct3  = inst[14:12];
        d.imm     = imm_b;
      end
      OPC_LUI, OPC_AUIPC: begin
        d.rdAddr = inst[11:7];
        d.imm    = imm_u;
      end
      OPC_JAL: begin
        d.rdAddr = inst[11:7];
        d.imm    = imm_j;
      end
      // fence, system and unknown opcodes keep only opcode and PC
      default: ;
    endcase
    return d;
  endfunction

  // A stage may load when it, or any stage downstream of it, has a free slot, or the output drains.
  always_comb begin
    for (int k = 0; k < cStages; k++) begin
      stage_en[k] = io.iReady;
      for (int j = k; j < cStages; j++) begin
        if (!v_q[j]) stage_en[k] = 1'b1;
      end
    end
  end

  assign io.oReady = !io.iFlush && stage_en[0];
  assign accept    = io.iValid && io.oReady;

  always_comb begin
    v_d = v_q;
    if (stage_en[0]) v_d[0] = accept;
    for (int k = 1; k < cStages; k++) begin
      if (stage_en[k]) v_d[k] = v_q[k-1];
    end
    if (io.iFlush) v_d = '0;
  end

  generate
    if (cStages == 1) begin : g_direct
      assign src_vld  = accept;
      assign src_inst = io.iInst;
      assign src_pc   = io.iCurPc;
    end else begin : g_raw
      logic [31:0] raw_inst_q [cStages-1];
      logic [31:0] raw_inst_d [cStages-1];
      logic [31:0] raw_pc_q   [cStages-1];
      logic [31:0] raw_pc_d   [cStages-1];

      always_comb begin
        raw_inst_d = raw_inst_q;
        raw_pc_d   = raw_pc_q;
        if (accept) begin
          raw_inst_d[0] = io.iInst;
          raw_pc_d[0]   = io.iCurPc;
        end
        for (int k = 1; k < cStages - 1; k++) begin
          if (stage_en[k] && v_q[k-1]) begin
            raw_inst_d[k] = raw_inst_q[k-1];
            raw_pc_d[k]   = raw_pc_q[k-1];
          end
        end
      end

      always_ff @(posedge iClk) begin
        raw_inst_q <= raw_inst_d;
        raw_pc_q   <= raw_pc_d;
      end

      assign src_vld  = v_q[cStages-2];
      assign src_inst = raw_inst_q[cStages-2];
      assign src_pc   = raw_pc_q[cStages-2];
    end
  endgenerate

  always_comb begin
    dec_d = dec_q;
    if (stage_en[cLast] && src_vld) dec_d = decode(src_inst, src_pc);
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      v_q   <= '0;
      dec_q <= '0;
    end else begin
      v_q   <= v_d;
      dec_q <= dec_d;
    end
  end

`ifdef INST_DECODE_ILLEGAL_CHK_EN
  logic ill_q, ill_d;

  function automatic logic is_illegal(input logic [31:0] inst);
    logic       bad;
    logic [2:0] f3;
    logic [6:0] f7;
    f3  = inst[14:12];
    f7  = inst[31:25];
    bad = (inst[1:0] != 2'b11) || (inst == 32'h0);
    case (inst[6:0])
      OPC_OP: begin
        if (!(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)))) bad = 1'b1;
      end
      OPC_OP_IMM: begin
        if (f3 == 3'b001 && f7 != 7'h00) bad = 1'b1;
        if (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20) bad = 1'b1;
      end
      OPC_LOAD, OPC_MISC_MEM, OPC_AUIPC, OPC_STORE, OPC_LUI,
      OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM: ;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  always_comb begin
    ill_d = ill_q;
    if (stage_en[cLast] && src_vld) ill_d = is_illegal(src_inst);
  end

  always_ff @(posedge iClk) begin
    if (iRst) ill_q <= 1'b0;
    else      ill_q <= ill_d;
  end

  assign io.oIllegal = v_q[cLast] && ill_q;
`else
  assign io.oIllegal = 1'b0;
`endif

  // An empty output stage presents a fixed idle word rather than stale data.
  always_comb begin
    idle_dec       = '0;
    idle_dec.curPc = cResetPc;
  end

  assign io.oValid   = v_q[cLast];
  assign io.oDecoded = v_q[cLast] ? dec_q : idle_dec;

endmodule

// File: tb/tb_inst_decode_pipe.sv
// Randomized and directed bench for inst_decode_pipe against a queue-based reference model.
module tb_inst_decode_pipe;
  import inst_decode_pipe_pkg::*;

  localparam int          cStages  = 2;
  localparam logic [31:0] cResetPc = 32'h8000_0000;
`ifdef INST_DECODE_ILLEGAL_CHK_EN
  localparam logic cChkEn = 1'b1;
`else
  localparam logic cChkEn = 1'b0;
`endif

  typedef struct {
    tDecodedInst dec;
    logic        ill;
    int          stamp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          n_out = 0;
  exp_t        q[$];
  logic        hold_pending = 1'b0;
  tDecodedInst held;
  logic        fired = 1'b0;
  tDecodedInst last_dec;
  logic        last_ill;
  logic        ready_seen_low;

  inst_decode_pipe_if bus();

  inst_decode_pipe #(.cStages(cStages), .cResetPc(cResetPc)) dut (
    .iClk (clk),
    .iRst (rst),
    .io   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic tDecodedInst idle();
    tDecodedInst d;
    d       = '0;
    d.curPc = cResetPc;
    return d;
  endfunction

  function automatic logic [31:0] sx(input int nbits, input logic [31:0] v);
    logic signed [31:0] t;
    t = $signed(v << (32 - nbits));
    return t >>> (32 - nbits);
  endfunction

  function automatic tDecodedInst ref_decode(input logic [31:0] inst, input logic [31:0] pc);
    tDecodedInst d;
    string       fmt;
    d        = '0;
    d.opcode = inst[6:0];
    d.curPc  = pc;
    fmt      = "-";
    if (inst[6:0] == 7'h33) fmt = "R";
    else if (inst[6:0] == 7'h03 || inst[6:0] == 7'h13 || inst[6:0] == 7'h67) fmt = "I";
    else if (inst[6:0] == 7'h23) fmt = "S";
    else if (inst[6:0] == 7'h63) fmt = "B";
    else if (inst[6:0] == 7'h37 || inst[6:0] == 7'h17) fmt = "U";
    else if (inst[6:0] == 7'h6F) fmt = "J";
    if (fmt == "R" || fmt == "I" || fmt == "S" || fmt == "B") begin
      d.rs1Addr = inst[19:15];
      d.funct3  = inst[14:12];
    end
    if (fmt == "R" || fmt == "S" || fmt == "B") d.rs2Addr = inst[24:20];
    if (fmt == "R" || fmt == "I" || fmt == "U" || fmt == "J") d.rdAddr = inst[11:7];
    if (fmt == "R") d.funct7 = inst[31:25];
    if (fmt == "I") d.imm = sx(12, inst >> 20);
    if (fmt == "S") d.imm = sx(12, ((inst >> 25) << 5) | ((inst >> 7) & 32'h1F));
    if (fmt == "B") d.imm = sx(13, ((inst >> 31) << 12) | (((inst >> 7) & 32'h1) << 11)
                                 | (((inst >> 25) & 32'h3F) << 5) | (((inst >> 8) & 32'hF) << 1));
    if (fmt == "U") d.imm = inst & 32'hFFFFF000;
    if (fmt == "J") d.imm = sx(21, ((inst >> 31) << 20) | (((inst >> 12) & 32'hFF) << 12)
                                 | (((inst >> 20) & 32'h1) << 11) | (((inst >> 21) & 32'h3FF) << 1));
    return d;
  endfunction

  function automatic logic ref_illegal(input logic [31:0] inst);
    logic       bad;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op  = inst[6:0];
    f3  = inst[14:12];
    f7  = inst[31:25];
    bad = (inst[1:0] != 2'b11) || (inst == 32'h0) ||
          !(op inside {7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73});
    if (op == 7'h33 && !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))) bad = 1'b1;
    if (op == 7'h13 && f3 == 3'd1 && f7 != 7'h00) bad = 1'b1;
    if (op == 7'h13 && f3 == 3'd5 && !(f7 == 7'h00 || f7 == 7'h20)) bad = 1'b1;
    return cChkEn && bad;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    w = $urandom();
    case ($urandom_range(0, 13))
      0: w[6:0] = 7'h37;
      1: w[6:0] = 7'h17;
      2: w[6:0] = 7'h6F;
      3: w[6:0] = 7'h67;
      4: w[6:0] = 7'h63;
      5: w[6:0] = 7'h03;
      6: w[6:0] = 7'h23;
      7: w[6:0] = 7'h0F;
      8: w[6:0] = 7'h73;
      9: w[6:0] = 7'h13;
      10: begin
        w[6:0] = 7'h33;
        case ($urandom_range(0, 3))
          0: w[31:25] = 7'h00;
          1: w[31:25] = 7'h20;
          2: w[31:25] = 7'h01;
          default: ;
        endcase
      end
      11: begin
        w[6:0]   = 7'h13;
        w[14:12] = ($urandom_range(0, 1) == 1) ? 3'b001 : 3'b101;
        case ($urandom_range(0, 2))
          0: w[31:25] = 7'h00;
          1: w[31:25] = 7'h20;
          default: ;
        endcase
      end
      12: w = 32'h0;
      default: ;
    endcase
    return w;
  endfunction

  // One clock: drive at negedge, compare against the model, then advance the model.
  task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                      input logic fl, input logic rdy);
    logic exp_rdy, exp_vld;
    exp_t e;
    @(negedge clk);
    bus.iValid = v;
    bus.iInst  = inst;
    bus.iCurPc = pc;
    bus.iFlush = fl;
    bus.iReady = rdy;
    #1;
    fired   = 1'b0;
    exp_rdy = !fl && (q.size() < cStages || rdy);
    exp_vld = 1'b0;
    if (q.size() > 0) exp_vld = (cyc - q[0].stamp >= cStages);
    check("oReady", bus.oReady, exp_rdy);
    if (!bus.oReady) ready_seen_low = 1'b1;
    check("oValid", bus.oValid, exp_vld);
    if (!exp_vld) begin
      check("idle_dec", bus.oDecoded, idle());
      check("idle_ill", bus.oIllegal, 1'b0);
    end
    if (hold_pending) check("hold_dec", bus.oDecoded, held);
    if (exp_vld && rdy) begin
      check("out_dec", bus.oDecoded, q[0].dec);
      check("out_ill", bus.oIllegal, q[0].ill);
      last_dec = bus.oDecoded;
      last_ill = bus.oIllegal;
      fired    = 1'b1;
      n_out++;
      void'(q.pop_front());
    end
    hold_pending = exp_vld && !rdy && !fl;
    held         = bus.oDecoded;
    if (fl) q.delete();
    if (v && exp_rdy) begin
      e.dec   = ref_decode(inst, pc);
      e.ill   = ref_illegal(inst);
      e.stamp = cyc;
      q.push_back(e);
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic run_dir(input logic [31:0] inst, input logic [31:0] pc, output int lat);
    step(1'b1, inst, pc, 1'b0, 1'b1);
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      lat++;
      if (fired) break;
    end
    if (!fired) check("dir_timeout", 1'b0, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (q.size() == 0) break;
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    end
    check("drain_empty", q.size(), 0);
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    rst        = 1'b1;
    bus.iValid = 1'b1;
    bus.iFlush = 1'b1;
    bus.iReady = 1'b0;
    bus.iInst  = 32'h0000_0013;
    bus.iCurPc = 32'h0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst        = 1'b0;
    bus.iValid = 1'b0;
    bus.iFlush = 1'b0;
    #1;
    check({tag, "_valid"}, bus.oValid, 1'b0);
    check({tag, "_ill"}, bus.oIllegal, 1'b0);
    check({tag, "_dec"}, bus.oDecoded, idle());
    check({tag, "_ready"}, bus.oReady, 1'b1);
    q.delete();
    hold_pending = 1'b0;
    @(posedge clk);
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, sent, n0;
    logic r, acc;
    rst        = 1'b1;
    bus.iValid = 1'b0;
    bus.iInst  = 32'h0;
    bus.iCurPc = 32'h0;
    bus.iFlush = 1'b0;
    bus.iReady = 1'b0;
    repeat (2) @(posedge clk);
    apply_reset("reset");

    run_dir(32'hFFF10093, 32'h0000_0100, lat);
    check("addi_lat", lat, cStages);
    check("addi_opc", last_dec.opcode, 7'h13);
    check("addi_rd", last_dec.rdAddr, 5'd1);
    check("addi_rs1", last_dec.rs1Addr, 5'd2);
    check("addi_rs2", last_dec.rs2Addr, 5'd0);
    check("addi_f3", last_dec.funct3, 3'd0);
    check("addi_imm", last_dec.imm, 32'hFFFFFFFF);
    check("addi_pc", last_dec.curPc, 32'h0000_0100);

    run_dir(32'hFE000EE3, 32'h0000_0104, lat);
    check("beq_imm", last_dec.imm, 32'hFFFFFFFC);
    check("beq_rd", last_dec.rdAddr, 5'd0);
    run_dir(32'h001000EF, 32'h0000_0108, lat);
    check("jal_rd", last_dec.rdAddr, 5'd1);
    check("jal_imm", last_dec.imm, 32'h00000800);
    run_dir(32'h00512423, 32'h0000_010C, lat);
    check("sw_rs1", last_dec.rs1Addr, 5'd2);
    check("sw_rs2", last_dec.rs2Addr, 5'd5);
    check("sw_f3", last_dec.funct3, 3'd2);
    check("sw_rd", last_dec.rdAddr, 5'd0);
    check("sw_imm", last_dec.imm, 32'd8);
    run_dir(32'h123451B7, 32'h0000_0110, lat);
    check("lui_rd", last_dec.rdAddr, 5'd3);
    check("lui_imm", last_dec.imm, 32'h12345000);

    run_dir(32'h00000000, 32'h0000_0200, lat);
    check("ill_zero", last_ill, cChkEn);
    run_dir(32'h40000033, 32'h0000_0204, lat);
    check("ill_sub", last_ill, 1'b0);
    run_dir(32'h02000033, 32'h0000_0208, lat);
    check("ill_mext", last_ill, cChkEn);

    // six back-to-back instructions with the sink stalled in cycles 3..5
    ready_seen_low = 1'b0;
    n0   = n_out;
    sent = 0;
    for (int c = 0; c < 40; c++) begin
      r   = !(c >= 3 && c <= 5);
      acc = (sent < 6) && (q.size() < cStages || r);
      step(sent < 6, rand_inst(), 32'h0000_1000 + 32'(sent * 4), 1'b0, r);
      if (acc) sent++;
      if (sent == 6 && q.size() == 0) break;
    end
    check("stream_count", n_out - n0, 6);
    check("stream_ready_drop", ready_seen_low, 1'b1);

    // flush a full, back-pressured pipe; the flush cycle also drains the output
    step(1'b1, 32'h00100093, 32'h0000_2000, 1'b0, 1'b0);
    step(1'b1, 32'h00200113, 32'h0000_2004, 1'b0, 1'b0);
    step(1'b1, 32'h00300193, 32'h0000_2008, 1'b1, 1'b1);
    check("flush_xfer", fired, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    run_dir(32'h00400213, 32'h0000_200C, lat);
    check("flush_lat", lat, cStages);
    check("flush_next_pc", last_dec.curPc, 32'h0000_200C);
    drain();

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, rand_inst(), $urandom() & 32'hFFFF_FFFC,
           $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7);
    end
    drain();

    step(1'b1, 32'h00500293, 32'h0000_3000, 1'b0, 1'b0);
    step(1'b1, 32'h00600313, 32'h0000_3004, 1'b0, 1'b0);
    apply_reset("midrst");
    run_dir(32'h00700393, 32'h0000_3008, lat);
    check("post_rst_lat", lat, cStages);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
